decoded_block_store: RTL and testbench

//  Append-only buffer of decoded lighthouse words (17b data + 24b timestamp) for one

---
 rtl/decoded_block_store_pkg.sv | 21 ++
 rtl/decoded_block_store_if.sv | 25 ++
 rtl/decoded_block_store_ram.sv | 21 ++
 rtl/decoded_block_store.sv | 110 +++++++++++
 tb/tb_decoded_block_store.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/decoded_block_store_pkg.sv
// Shared widths and read-FSM encoding for the decoded block store.
// polynomial_manager sizes its per-channel ports from the same widths.
package decoded_block_store_pkg;
    localparam int DATA_W     = 17;
    localparam int TS_W       = 24;
    localparam int BLOCK_W    = DATA_W + TS_W;
    localparam int BLOCK_NB_W = 8;

    typedef logic [BLOCK_W-1:0]    block_t;
    typedef logic [BLOCK_NB_W-1:0] block_nb_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_READY = 2'd2
    } rstate_t;

    function automatic block_t pack_block(input logic [DATA_W-1:0] d, input logic [TS_W-1:0] ts);
        return {d, ts};
    endfunction
endpackage

// File: rtl/decoded_block_store_if.sv
// Decoder-side write strobes and manager-side read handshake of one channel's store.
interface decoded_block_store_if;
    import decoded_block_store_pkg::*;

    logic [DATA_W-1:0] decoded_data;
    logic [TS_W-1:0]   ts_decoded_data;
    logic              data_valid;
    logic              clear;
    logic              lock;
    block_nb_t         block_wanted_number;
    block_t            ram_block_wanted;
    logic              ram_data_ready;
    block_nb_t         avl_blocks_nb;
    logic              overflow;

    modport master (
        output decoded_data, ts_decoded_data, data_valid, clear, lock, block_wanted_number,
        input  ram_block_wanted, ram_data_ready, avl_blocks_nb, overflow
    );

    modport slave (
        input  decoded_data, ts_decoded_data, data_valid, clear, lock, block_wanted_number,
        output ram_block_wanted, ram_data_ready, avl_blocks_nb, overflow
    );
endinterface

// File: rtl/decoded_block_store_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on
// the array or read register so it maps onto iCE40 EBR.
module block_ram_sdp #(
    parameter int DEPTH = 255,
    parameter int W     = 41,
    parameter int AW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/decoded_block_store.sv
// Append-only store of decoded lighthouse words for one sensor channel, served to
// the polynomial manager by 1-based block number.
module decoded_block_store
    import decoded_block_store_pkg::*;
#(
    parameter int DEPTH        = 255,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_72MHz,
    input  logic                  reset_n,
    decoded_block_store_if.slave  bus
);
    localparam block_nb_t DEPTH_NB = block_nb_t'(DEPTH);
    localparam block_nb_t RL_LAST  = block_nb_t'(READ_LATENCY - 1);

    block_nb_t r_avl, r_req_q, r_cnt, w_cnt_nxt, w_raddr;
    logic      r_ovf, r_rdy, w_rdy_nxt, w_full, w_we, w_req_ok, w_req_chg;
    block_t    r_data, w_data_nxt, w_rdata;
    rstate_t   r_state, w_state_nxt;

    assign w_full = (r_avl == DEPTH_NB);
    assign w_we   = bus.data_valid && !bus.clear && !bus.lock && !w_full;

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_avl <= '0;
            r_ovf <= 1'b0;
        end else if (bus.clear) begin
            r_avl <= '0;
            r_ovf <= 1'b0;
        end else if (!bus.lock && bus.data_valid) begin
            if (w_full) r_ovf <= 1'b1;
            else        r_avl <= r_avl + 8'd1;
        end
    end

    // Read address follows the live request so the RAM output is already valid
    // for block n on the first R_WAIT cycle; block 0 never reaches the subtract.
    assign w_req_ok  = (bus.block_wanted_number != '0) && (bus.block_wanted_number <= r_avl);
    assign w_req_chg = (bus.block_wanted_number != r_req_q);
    assign w_raddr   = (bus.block_wanted_number == '0) ? '0 : bus.block_wanted_number - 8'd1;

    block_ram_sdp #(.DEPTH(DEPTH), .W(BLOCK_W), .AW(BLOCK_NB_W)) u_ram (
        .i_clk   (clk_72MHz),
        .i_we    (w_we),
        .i_waddr (r_avl),
        .i_wdata (pack_block(bus.decoded_data, bus.ts_decoded_data)),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdy_nxt   = r_rdy;
        w_data_nxt  = r_data;
        case (r_state)
            R_IDLE: begin
                w_rdy_nxt  = 1'b0;
                w_data_nxt = '0;
                if (w_req_ok && !bus.clear) begin
                    w_state_nxt = R_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            R_WAIT, R_READY: begin
                // Any request change or loss of range drops ready before new data can appear.
                if (w_req_chg || bus.clear || !w_req_ok) begin
                    w_state_nxt = R_IDLE;
                    w_rdy_nxt   = 1'b0;
                    w_data_nxt  = '0;
                end else if (r_state == R_WAIT) begin
                    if (r_cnt == RL_LAST) begin
                        w_data_nxt  = w_rdata;
                        w_rdy_nxt   = 1'b1;
                        w_state_nxt = R_READY;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = R_IDLE;
                w_rdy_nxt   = 1'b0;
                w_data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
            r_data  <= '0;
            r_req_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdy   <= w_rdy_nxt;
            r_data  <= w_data_nxt;
            r_req_q <= bus.block_wanted_number;
        end
    end

    assign bus.ram_block_wanted = r_data;
    assign bus.ram_data_ready   = r_rdy;
    assign bus.avl_blocks_nb    = r_avl;
    assign bus.overflow         = r_ovf;
endmodule

// File: tb/tb_decoded_block_store.sv
// Directed bench for decoded_block_store: stimulus queues expected read blocks,
// a negedge monitor checks each block as ready rises and while it is held.
module tb_decoded_block_store;
    import decoded_block_store_pkg::*;

    localparam int DEPTH = 255;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoded_block_store_if bus();

    decoded_block_store #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk_72MHz (clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    int     errors = 0;
    int     checks = 0;
    block_t exp_q[$];
    block_t held = '0;
    logic   prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy = 1'b0;
        end else begin
            if (bus.ram_data_ready && !prev_rdy) begin
                if (exp_q.size() == 0) chk("unexpected_ready", 64'(bus.ram_data_ready), 64'd0);
                else begin
                    held = exp_q.pop_front();
                    chk("rd_data", 64'(bus.ram_block_wanted), 64'(held));
                end
            end else if (bus.ram_data_ready) begin
                chk("rd_hold", 64'(bus.ram_block_wanted), 64'(held));
            end
            prev_rdy = bus.ram_data_ready;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic append(input logic [16:0] d, input logic [23:0] ts);
        bus.decoded_data    = d;
        bus.ts_decoded_data = ts;
        bus.data_valid      = 1'b1;
        step();
        bus.data_valid      = 1'b0;
    endtask

    // extra=1 when leaving a held/pending read: one cycle back through R_IDLE.
    task automatic req(input block_nb_t n, input block_t exp, input bit exp_rdy, input int extra);
        bus.block_wanted_number = n;
        if (exp_rdy) exp_q.push_back(exp);
        for (int i = 0; i <= RL + extra; i++) begin
            step();
            chk($sformatf("rdy_n%0d_c%0d", n, i), 64'(bus.ram_data_ready),
                64'(exp_rdy && (i == RL + extra)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.decoded_data        = '0;
        bus.ts_decoded_data     = '0;
        bus.data_valid          = 1'b0;
        bus.clear               = 1'b0;
        bus.lock                = 1'b0;
        bus.block_wanted_number = '0;
        step();
        step();
        chk("rst_avl",  64'(bus.avl_blocks_nb), 64'd0);
        chk("rst_ovf",  64'(bus.overflow), 64'd0);
        chk("rst_rdy",  64'(bus.ram_data_ready), 64'd0);
        chk("rst_data", 64'(bus.ram_block_wanted), 64'd0);
        rst_n = 1'b1;
        step();

        // basic append + read of block 2
        append(17'h00011, 24'h000100);
        append(17'h00022, 24'h000200);
        append(17'h00033, 24'h000300);
        chk("t1_avl", 64'(bus.avl_blocks_nb), 64'd3);
        req(8'd2, {17'h00022, 24'h000200}, 1'b1, 0);

        // switch request while ready, then drop to 0
        req(8'd3, {17'h00033, 24'h000300}, 1'b1, 1);
        bus.block_wanted_number = 8'd0;
        step();
        chk("t2_rdy0",  64'(bus.ram_data_ready), 64'd0);
        chk("t2_data0", 64'(bus.ram_block_wanted), 64'd0);

        // lock freezes count; out-of-range request never ready
        bus.lock = 1'b1;
        for (int i = 0; i < 5; i++) append(17'(i) | 17'h0AA00, 24'h0BB000);
        bus.lock = 1'b0;
        chk("t4_avl", 64'(bus.avl_blocks_nb), 64'd3);
        req(8'd4, '0, 1'b0, 0);
        bus.block_wanted_number = 8'd0;
        step();

        // appends every cycle while block 1 is held
        req(8'd1, {17'h00011, 24'h000100}, 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            append(17'(i) | 17'h00100, 24'(i) | 24'h000400);
            chk("t6_hold_rdy",  64'(bus.ram_data_ready), 64'd1);
            chk("t6_hold_data", 64'(bus.ram_block_wanted), 64'({17'h00011, 24'h000100}));
        end
        chk("t6_avl", 64'(bus.avl_blocks_nb), 64'd13);
        bus.block_wanted_number = 8'd0;
        step();

        // fill to DEPTH, overflow, read last block, clear while ready
        for (int i = 13; i < DEPTH; i++) append(17'(i) | 17'h10000, 24'(i) | 24'hF00000);
        chk("t3_full_avl", 64'(bus.avl_blocks_nb), 64'd255);
        chk("t3_full_ovf", 64'(bus.overflow), 64'd0);
        append(17'h1FFFF, 24'hFFFFFF);
        chk("t3_sat_avl", 64'(bus.avl_blocks_nb), 64'd255);
        chk("t3_ovf", 64'(bus.overflow), 64'd1);
        req(8'd255, {17'h100FE, 24'hF000FE}, 1'b1, 0);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("t3_clr_rdy",  64'(bus.ram_data_ready), 64'd0);
        chk("t3_clr_data", 64'(bus.ram_block_wanted), 64'd0);
        chk("t3_clr_avl",  64'(bus.avl_blocks_nb), 64'd0);
        chk("t3_clr_ovf",  64'(bus.overflow), 64'd0);
        step();
        chk("t3_clr_rdy2", 64'(bus.ram_data_ready), 64'd0);
        bus.block_wanted_number = 8'd0;
        bus.clear = 1'b1;
        append(17'h01234, 24'h005678);
        bus.clear = 1'b0;
        chk("t3_clr_dv_avl", 64'(bus.avl_blocks_nb), 64'd0);

        // async reset mid R_WAIT, then recover
        append(17'h1ABCD, 24'hABCDEF);
        chk("t5_avl1", 64'(bus.avl_blocks_nb), 64'd1);
        bus.block_wanted_number = 8'd1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_avl",  64'(bus.avl_blocks_nb), 64'd0);
        chk("t5_rst_rdy",  64'(bus.ram_data_ready), 64'd0);
        chk("t5_rst_data", 64'(bus.ram_block_wanted), 64'd0);
        chk("t5_rst_ovf",  64'(bus.overflow), 64'd0);
        bus.block_wanted_number = 8'd0;
        step();
        rst_n = 1'b1;
        step();
        append(17'h05555, 24'h123456);
        req(8'd1, {17'h05555, 24'h123456}, 1'b1, 0);
        bus.block_wanted_number = 8'd0;
        step();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
